// File: rtl/seqgen_pkg.sv
// Shared definitions for the Moore sequence generator: state encoding,
// default symbol width and the fixed symbol table.
package seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SYM_W_DEF = 4;
  localparam int TABLE_LEN = 16;

  localparam logic [SYM_W_DEF-1:0] SEQ_TABLE [TABLE_LEN] = '{
    4'h3, 4'h9, 4'h5, 4'hC,
    4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0
  };

  // Table lookup kept in one place so the decode never indexes the array directly.
  function automatic logic [SYM_W_DEF-1:0] seq_sym(input logic [3:0] idx);
    return SEQ_TABLE[idx];
  endfunction

endpackage

// File: rtl/seqgen_next_state.sv
// Next-state and next-index logic for the sequence generator.
// Optional wrap-around on the last symbol is enabled by macro SEQGEN_LOOP_EN.
module seqgen_next_state
  import seqgen_pkg::*;
#(
  parameter int SEQ_LEN = 4
) (
  input  state_e     state_q_i,
  input  logic [3:0] idx_q_i,
  input  logic       start_i,
  input  logic       ready_i,
`ifdef SEQGEN_LOOP_EN
  input  logic       loop_i,
`endif
  output state_e     state_d_o,
  output logic [3:0] idx_d_o,
  output logic       wrap_d_o
);

  localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

  // Transition function: advance only on an accepted symbol, hold on stall.
  always_comb begin
    state_d_o = state_q_i;
    idx_d_o   = idx_q_i;
    wrap_d_o  = 1'b0;
    case (state_q_i)
      IDLE: begin
        if (start_i) begin
          state_d_o = SEND;
          idx_d_o   = 4'd0;
        end else begin
          idx_d_o   = 4'd0;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (idx_q_i >= LAST_IDX) begin
`ifdef SEQGEN_LOOP_EN
            if (loop_i) begin
              idx_d_o  = 4'd0;
              wrap_d_o = 1'b1;
            end else begin
              state_d_o = DONE;
              idx_d_o   = 4'd0;
            end
`else
            state_d_o = DONE;
            idx_d_o   = 4'd0;
`endif
          end else begin
            idx_d_o = idx_q_i + 4'd1;
          end
        end else begin
          idx_d_o = idx_q_i;
        end
      end
      DONE: begin
        state_d_o = IDLE;
        idx_d_o   = 4'd0;
      end
      default: begin
        state_d_o = IDLE;
        idx_d_o   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/moore_seq_gen.sv
// Moore sequence generator: emits SEQ_LEN symbols from SEQ_TABLE with a
// Valid/Ready handshake, then a one-cycle Done pulse.
// Optional feature macro: SEQGEN_LOOP_EN adds the Loop input (continuous repeat).
module moore_seq_gen
  import seqgen_pkg::*;
#(
  parameter int SEQ_LEN = 4,
  parameter int SYM_W   = SYM_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ready,
`ifdef SEQGEN_LOOP_EN
  input  logic             Loop,
`endif
  output logic [SYM_W-1:0] Output,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             wrap_d;
  logic [SYM_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  seqgen_next_state #(.SEQ_LEN(SEQ_LEN)) u_next (
    .state_q_i (state_q),
    .idx_q_i   (idx_q),
    .start_i   (Start),
    .ready_i   (Ready),
`ifdef SEQGEN_LOOP_EN
    .loop_i    (Loop),
`endif
    .state_d_o (state_d),
    .idx_d_o   (idx_d),
    .wrap_d_o  (wrap_d)
  );

  // Output decode from the upcoming state/index so the flops hold exactly
  // what the registered state implies (pure Moore, no input feed-through).
  always_comb begin
    out_d   = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = wrap_d;
    case (state_d)
      SEND: begin
        out_d   = SYM_W'(seq_sym(idx_d));
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        out_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, index and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Output = out_q;
  assign Valid  = valid_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: doc/moore_seq_gen.md
MOORE_SEQ_GEN -- requirements
Module: moore_seq_gen

Interface
REQ-001 SHALL provide parameter SEQ_LEN, default 4: number of symbols emitted per sequence, legal range 1..16.
REQ-002 SHALL provide parameter SYM_W, default 4: symbol width in bits.
REQ-003 SHALL provide port CLK  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port Reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL provide port Start  input  1: request to emit one sequence; sampled only in IDLE.
REQ-006 SHALL provide port Ready  input  1: downstream accepts the current symbol this cycle.
REQ-007 SHALL provide port Output  output  SYM_W: current symbol, registered (Moore).
REQ-008 SHALL provide port Valid  output  1: Output holds a sequence symbol.
REQ-009 SHALL provide port Busy  output  1: high in SEND and DONE.
REQ-010 SHALL provide port Done  output  1: one-cycle pulse after the last symbol is accepted.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, SEND, DONE; all outputs are decoded from the registered state and index only.
REQ-012 IDLE: Output=0, Valid=0, Busy=0, Done=0; Start=1 -> SEND with index=0 on the next edge.
REQ-013 SEND: Valid=1, Output=SEQ_TABLE[index]; the first symbol appears one cycle after Start is sampled.
REQ-014 SEND with Ready=0: index and Output SHALL hold unchanged (no symbol lost or skipped).
REQ-015 SEND with Ready=1 and index<SEQ_LEN-1: index increments by 1, state stays SEND.
REQ-016 SEND with Ready=1 and index=SEQ_LEN-1: -> DONE, index cleared to 0.
REQ-017 DONE: Valid=0, Done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-018 Start SHALL be ignored in SEND and DONE; a new sequence needs Start in IDLE.
REQ-019 Index register SHALL be 4 bits and never exceed SEQ_LEN-1.
REQ-020 SEQ_LEN=1: a single symbol is sent; DONE follows its acceptance.

Reset
REQ-021 Reset=0 SHALL force IDLE, index=0, Output=0, Valid=0, Busy=0, Done=0 immediately, independent of CLK.
REQ-022 Reset asserted mid-sequence SHALL abort it with no Done pulse; the first edge after release starts in IDLE.

Configuration
REQ-023 Macro SEQGEN_LOOP_EN, when defined, SHALL add input port Loop (1 bit).
REQ-024 With SEQGEN_LOOP_EN, Loop=1 when the last symbol is accepted: index wraps to 0, state stays SEND, Done pulses for that cycle concurrently with Valid=1.
REQ-025 With SEQGEN_LOOP_EN, Loop=0 at the last symbol: behaviour identical to REQ-016/017.
REQ-026 Without SEQGEN_LOOP_EN: no Loop port; every sequence ends via DONE.

Structure
REQ-027 Shared package seqgen_pkg SHALL hold the state enum (IDLE, SEND, DONE), SYM_W default, and SEQ_TABLE: 16 entries of SYM_W bits, entries 0..3 = 4'h3, 4'h9, 4'h5, 4'hC, remaining entries 4'h0.
REQ-028 Next-state/index logic SHALL be one sub-module seqgen_next_state; the top holds the state/index registers and output decode.

Verification
REQ-029 Reset low, then Start pulse, Ready=1 constant -> Output 3,9,5,C on four consecutive cycles with Valid=1, then Done=1 one cycle, then IDLE, Output=0.
REQ-030 Ready=0 for 3 cycles while Output=9 -> Output stays 9, Valid stays 1; Ready=1 resumes with 5, C.
REQ-031 Start held high throughout the sequence -> exactly one sequence, a second begins only after returning to IDLE.
REQ-032 Reset=0 mid-sequence while Output=5 -> outputs zero immediately, Done never pulses, Busy=0.
REQ-033 SEQGEN_LOOP_EN defined, Loop=1, Ready=1 -> 3,9,5,C,3,9... with Done=1 coincident with each wrap; Loop=0 -> ends via DONE.
REQ-034 SEQ_LEN=1 with Ready=1 -> single symbol 3, then Done pulse, then IDLE.
